alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single 32-bit ALU (AND/OR/XOR/ADD/SUB, 3-bit select, 33-bit result) between NREQ requesters. It sits directly in front of the ALU instance:
- accepts one operation at a time through a valid/ready handshake;
- drives the ALU operand and select inputs from registers and captures the 33-bit result;
- returns the result to the winning requester with a one-hot response strobe and backpressure.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_arbiter_rr_select.sv | 36 +++
 rtl/alu_arbiter.sv | 133 +++++++++++++
 tb/tb_alu_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants, state encoding and request payload for the ALU arbiter slice.
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned RES_W  = 33;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_AND = 3'd0;
  localparam logic [OP_W-1:0] OP_OR  = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR = 3'd2;
  localparam logic [OP_W-1:0] OP_ADD = 3'd3;
  localparam logic [OP_W-1:0] OP_SUB = 3'd4;
  localparam logic [OP_W-1:0] OP_MAX = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } alu_req_t;

  // Select codes above OP_MAX have no ALU meaning and are answered with an error.
  function automatic logic op_invalid(input logic [OP_W-1:0] op);
    return op > OP_MAX;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_select.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_select #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned RRW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [RRW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [RRW-1:0]  idx,
  output logic            any
);

  logic [RRW:0] pos;

  // Scan NREQ positions starting at ptr; pos carries one spare bit for the wrap.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      pos = (RRW+1)'(ptr) + (RRW+1)'(i);
      if (pos >= (RRW+1)'(NREQ)) begin
        pos = pos - (RRW+1)'(NREQ);
      end
      if (!any && req[pos[RRW-1:0]]) begin
        any = 1'b1;
        idx = pos[RRW-1:0];
      end
    end
    if (any) begin
      gnt = NREQ'(1) << idx;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between NREQ requesters: arbitrate, issue, return result.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned RRW  = 2
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [NREQ-1:0]          ReqValid,
  input  logic [OP_W*NREQ-1:0]     ReqOp,
  input  logic [DATA_W*NREQ-1:0]   ReqA,
  input  logic [DATA_W*NREQ-1:0]   ReqB,
  output logic [NREQ-1:0]          ReqReady,
  output logic [NREQ-1:0]          RspValid,
  output logic [RES_W-1:0]         RspData,
  output logic                     RspErr,
  input  logic                     RspReady,
  output logic [DATA_W-1:0]        AluIn1,
  output logic [DATA_W-1:0]        AluIn2,
  output logic [OP_W-1:0]          AluSel,
  input  logic [RES_W-1:0]         AluOut,
  output logic                     Busy
);

  state_t          state;
  state_t          state_next;
  logic [RRW-1:0]  ptr;
  logic [RRW-1:0]  gnt_idx;
  logic            err_flag;

  logic [NREQ-1:0] sel_gnt;
  logic [RRW-1:0]  sel_idx;
  logic            sel_any;
  alu_req_t        sel_req;

  logic            accept;
  logic            capture;
  logic            release_rsp;

  rr_select #(
    .NREQ (NREQ),
    .RRW  (RRW)
  ) u_rr_select (
    .req (ReqValid),
    .ptr (ptr),
    .gnt (sel_gnt),
    .idx (sel_idx),
    .any (sel_any)
  );

  // Payload of the currently selected requester.
  always_comb begin
    sel_req = '{
      op: ReqOp[OP_W*32'(sel_idx) +: OP_W],
      a:  ReqA[DATA_W*32'(sel_idx) +: DATA_W],
      b:  ReqB[DATA_W*32'(sel_idx) +: DATA_W]
    };
  end

  // Next-state and handshake decode; the grant is suppressed while reset is high.
  always_comb begin
    state_next  = state;
    ReqReady    = '0;
    accept      = 1'b0;
    capture     = 1'b0;
    release_rsp = 1'b0;
    case (state)
      IDLE: begin
        if (!Rst && sel_any) begin
          ReqReady   = sel_gnt;
          accept     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        capture    = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        if (RspReady) begin
          release_rsp = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand issue, result capture, response strobe and round-robin pointer.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ptr      <= '0;
      gnt_idx  <= '0;
      err_flag <= 1'b0;
      AluIn1   <= '0;
      AluIn2   <= '0;
      AluSel   <= '0;
      RspValid <= '0;
      RspData  <= '0;
      RspErr   <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      if (accept) begin
        AluIn1   <= sel_req.a;
        AluIn2   <= sel_req.b;
        AluSel   <= sel_req.op;
        gnt_idx  <= sel_idx;
        err_flag <= op_invalid(sel_req.op);
        ptr      <= (sel_idx == RRW'(NREQ - 1)) ? '0 : sel_idx + RRW'(1);
      end
      if (capture) begin
        RspData  <= err_flag ? '0 : AluOut;
        RspErr   <= err_flag;
        RspValid <= NREQ'(1) << gnt_idx;
      end
      if (release_rsp) begin
        RspValid <= '0;
      end
      Busy <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU and reference model.
module tb_alu_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned RRW  = 2;

  logic              Clk = 1'b0;
  logic              Rst;
  logic [NREQ-1:0]   ReqValid;
  logic [3*NREQ-1:0] ReqOp;
  logic [32*NREQ-1:0] ReqA;
  logic [32*NREQ-1:0] ReqB;
  logic [NREQ-1:0]   ReqReady;
  logic [NREQ-1:0]   RspValid;
  logic [32:0]       RspData;
  logic              RspErr;
  logic              RspReady;
  logic [31:0]       AluIn1;
  logic [31:0]       AluIn2;
  logic [2:0]        AluSel;
  logic [32:0]       AluOut;
  logic              Busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [NREQ-1:0] vld;
  logic [31:0]     a_q  [NREQ];
  logic [31:0]     b_q  [NREQ];
  logic [2:0]      op_q [NREQ];
  int              ptr_m;

  alu_arbiter #(
    .NREQ (NREQ),
    .RRW  (RRW)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .ReqValid (ReqValid),
    .ReqOp    (ReqOp),
    .ReqA     (ReqA),
    .ReqB     (ReqB),
    .ReqReady (ReqReady),
    .RspValid (RspValid),
    .RspData  (RspData),
    .RspErr   (RspErr),
    .RspReady (RspReady),
    .AluIn1   (AluIn1),
    .AluIn2   (AluIn2),
    .AluSel   (AluSel),
    .AluOut   (AluOut),
    .Busy     (Busy)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // External ALU; undefined selects return garbage so error zeroing is visible.
  always_comb begin
    case (AluSel)
      3'd0:    AluOut = {1'b0, AluIn1 & AluIn2};
      3'd1:    AluOut = {1'b0, AluIn1 | AluIn2};
      3'd2:    AluOut = {1'b0, AluIn1 ^ AluIn2};
      3'd3:    AluOut = {1'b0, AluIn1} + {1'b0, AluIn2};
      3'd4:    AluOut = {1'b0, AluIn1} - {1'b0, AluIn2};
      default: AluOut = 33'h1_DEAD_BEEF;
    endcase
  end

  // Expected response data from plain 64-bit arithmetic reduced modulo 2^33.
  function automatic logic [32:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint unsigned x;
    longint unsigned y;
    x = 64'(a);
    y = 64'(b);
    case (op)
      3'd0:    return 33'(x & y);
      3'd1:    return 33'(x | y);
      3'd2:    return 33'(x ^ y);
      3'd3:    return 33'(x + y);
      3'd4:    return 33'(x - y);
      default: return 33'd0;
    endcase
  endfunction

  // First valid requester at or after p, wrapping modulo NREQ.
  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < int'(NREQ); k++) begin
      int j;
      j = (p + k) % int'(NREQ);
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    ReqValid = vld;
    for (int i = 0; i < int'(NREQ); i++) begin
      ReqA[32*i +: 32] = a_q[i];
      ReqB[32*i +: 32] = b_q[i];
      ReqOp[3*i +: 3]  = op_q[i];
    end
  endtask

  task automatic new_payload(input int r, input bit valid_ops_only);
    a_q[r]  = $urandom;
    b_q[r]  = $urandom;
    op_q[r] = valid_ops_only ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
  endtask

  // One full transaction from the current IDLE cycle; starts and ends at posedge+1.
  task automatic issue(input int bp, input bit refresh, input int exp_g, output int acc_cyc);
    int          g;
    logic [32:0] er;
    logic        ee;
    drive();
    #1;
    g = pick(vld, ptr_m);
    if (exp_g >= 0) chk("rr_order", 64'(ReqReady), 64'(NREQ'(1) << exp_g));
    chk("grant", 64'(ReqReady), 64'(NREQ'(1) << g));
    chk("busy_idle", 64'(Busy), 64'(0));
    er = ref_result(op_q[g], a_q[g], b_q[g]);
    ee = (op_q[g] > 3'd4);
    @(posedge Clk); #1;
    acc_cyc = cyc;
    ptr_m   = (g + 1) % int'(NREQ);
    chk("alu_in1", 64'(AluIn1), 64'(a_q[g]));
    chk("alu_in2", 64'(AluIn2), 64'(b_q[g]));
    chk("alu_sel", 64'(AluSel), 64'(op_q[g]));
    chk("busy_exec", 64'(Busy), 64'(1));
    chk("ready_exec", 64'(ReqReady), 64'(0));
    chk("rspv_exec", 64'(RspValid), 64'(0));
    if (refresh) new_payload(g, 1'b0);
    else vld[g] = 1'b0;
    if (bp > 0) RspReady = 1'b0;
    drive();
    @(posedge Clk); #1;
    chk("rsp_valid", 64'(RspValid), 64'(NREQ'(1) << g));
    chk("rsp_data", 64'(RspData), 64'(er));
    chk("rsp_err", 64'(RspErr), 64'(ee));
    chk("ready_resp", 64'(ReqReady), 64'(0));
    for (int k = 0; k < bp; k++) begin
      @(posedge Clk); #1;
      chk("hold_valid", 64'(RspValid), 64'(NREQ'(1) << g));
      chk("hold_data", 64'(RspData), 64'(er));
      chk("hold_ready", 64'(ReqReady), 64'(0));
    end
    RspReady = 1'b1;
    @(posedge Clk); #1;
    chk("rsp_clear", 64'(RspValid), 64'(0));
    chk("busy_done", 64'(Busy), 64'(0));
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst   = 1'b0;
    ptr_m = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int last_acc;
    for (int i = 0; i < int'(NREQ); i++) new_payload(i, 1'b1);
    Rst      = 1'b1;
    RspReady = 1'b1;
    vld      = '1;
    drive();
    @(posedge Clk); #1;
    // Reset values, with every request valid while reset is high
    chk("rst_ready", 64'(ReqReady), 64'(0));
    chk("rst_rspv", 64'(RspValid), 64'(0));
    chk("rst_data", 64'(RspData), 64'(0));
    chk("rst_err", 64'(RspErr), 64'(0));
    chk("rst_in1", 64'(AluIn1), 64'(0));
    chk("rst_in2", 64'(AluIn2), 64'(0));
    chk("rst_sel", 64'(AluSel), 64'(0));
    chk("rst_busy", 64'(Busy), 64'(0));
    Rst   = 1'b0;
    ptr_m = 0;
    vld   = '0;
    drive();
    #1;
    chk("idle_ready", 64'(ReqReady), 64'(0));
    @(posedge Clk); #1;
    chk("idle_busy", 64'(Busy), 64'(0));

    // ADD carry out from requester 0
    vld = 4'b0001; op_q[0] = 3'd3; a_q[0] = 32'hFFFF_FFFF; b_q[0] = 32'd1;
    issue(0, 1'b0, 0, acc);
    // SUB borrow from requester 2
    vld = 4'b0100; op_q[2] = 3'd4; a_q[2] = 32'd1; b_q[2] = 32'd2;
    issue(0, 1'b0, 2, acc);
    // Undefined select from requester 1
    vld = 4'b0010; op_q[1] = 3'd6; a_q[1] = 32'h1234_5678; b_q[1] = 32'h9ABC_DEF0;
    issue(0, 1'b0, 1, acc);
    // Response backpressure for 5 cycles
    vld = 4'b1000; op_q[3] = 3'd2; a_q[3] = 32'hA5A5_0F0F; b_q[3] = 32'hFFFF_0000;
    issue(5, 1'b0, 3, acc);

    // Fairness with all requesters continuously valid from pointer 0
    do_reset();
    for (int i = 0; i < int'(NREQ); i++) new_payload(i, 1'b1);
    vld = '1;
    last_acc = 0;
    for (int i = 0; i < 5; i++) begin
      issue(0, 1'b1, i % int'(NREQ), acc);
      if (i > 0) chk("issue_gap", 64'(acc - last_acc), 64'(3));
      last_acc = acc;
    end

    // Reset while in EXEC discards the transaction and clears the pointer
    vld = 4'b0100;
    drive();
    #1;
    chk("mid_grant", 64'(ReqReady), 64'(4'b0100));
    @(posedge Clk); #1;
    chk("mid_busy", 64'(Busy), 64'(1));
    Rst = 1'b1;
    vld = '1;
    drive();
    #1;
    chk("mid_rst_ready", 64'(ReqReady), 64'(0));
    @(posedge Clk); #1;
    chk("mid_rst_busy", 64'(Busy), 64'(0));
    chk("mid_rst_rspv", 64'(RspValid), 64'(0));
    chk("mid_rst_in1", 64'(AluIn1), 64'(0));
    Rst   = 1'b0;
    ptr_m = 0;
    vld   = '0;
    drive();
    for (int k = 0; k < 2; k++) begin
      @(posedge Clk); #1;
      chk("mid_no_rsp", 64'(RspValid), 64'(0));
    end
    vld = '1;
    issue(0, 1'b0, 0, acc);

    // Random traffic against the reference model
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!vld[i] && ($urandom_range(0, 1) == 1)) begin
          new_payload(i, 1'b0);
          vld[i] = 1'b1;
        end else if (vld[i] && ($urandom_range(0, 3) == 0)) begin
          vld[i] = 1'b0;
        end
      end
      if (vld == '0) begin
        drive();
        #1;
        chk("rnd_idle_ready", 64'(ReqReady), 64'(0));
        @(posedge Clk); #1;
        chk("rnd_idle_busy", 64'(Busy), 64'(0));
        vld[$urandom_range(0, NREQ - 1)] = 1'b1;
      end
      issue(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), -1, acc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
